tnkk_select_array_unit: RTL and testbench

TNKK_SELECT_ARRAY_UNIT -- requirements
Module: tnkk_select_array

---
 rtl/tnkk_select_array_unit_pkg.sv | 15 +
 rtl/tnkk_select_array_unit_ternary_select.sv | 27 ++
 rtl/tnkk_select_array_unit.sv | 51 +++++
 tb/tb_tnkk_select_array_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tnkk_select_array_unit_pkg.sv
// Shared network parameters for the ternary select array: default geometry
// and the 2-bit ternary weight codes.
package tnkk_select_array_unit_pkg;

  localparam int TN_DEF            = 4;
  localparam int FEATURE_WIDTH_DEF = 16;
  localparam int KERNEL_SIZE_DEF   = 3;
  localparam int KERNEL_WIDTH_DEF  = 2;

  // Only the two low weight bits carry meaning; 2'b10 behaves like ZERO.
  localparam logic [1:0] POS  = 2'b01;
  localparam logic [1:0] NEG  = 2'b11;
  localparam logic [1:0] ZERO = 2'b00;

endpackage

// File: rtl/tnkk_select_array_unit_ternary_select.sv
// Single ternary lane: passes, negates or zeroes one feature according to
// its weight code. Purely combinational.
module ternary_select_unit
  import tnkk_select_array_unit_pkg::*;
#(
  parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
  parameter int KERNEL_WIDTH  = KERNEL_WIDTH_DEF
) (
  input  logic [FEATURE_WIDTH-1:0] feature,
  input  logic [KERNEL_WIDTH-1:0]  weight,
  output logic [FEATURE_WIDTH-1:0] result
);

  logic [1:0] code;

  always_comb begin
    code   = weight[1:0];
    result = '0;
    case (code)
      POS:     result = feature;
      // Plain wrapping negation: the most negative value maps to itself.
      NEG:     result = '0 - feature;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/tnkk_select_array_unit.sv
// Ternary select array: Tn*K*K independent lanes, each selecting +f, -f or 0,
// registered together with a one-cycle completion strobe.
module tnkk_select_array_unit
  import tnkk_select_array_unit_pkg::*;
#(
  parameter int Tn            = TN_DEF,
  parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
  parameter int KERNEL_SIZE   = KERNEL_SIZE_DEF,
  parameter int KERNEL_WIDTH  = KERNEL_WIDTH_DEF
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     enable,
  input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0]      feature_in,
  input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*KERNEL_WIDTH-1:0]       weight_in,
  output logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0]      feature_out,
  output logic                                                     ternary_com_done
);

  localparam int N = Tn * KERNEL_SIZE * KERNEL_SIZE;

  logic [N*FEATURE_WIDTH-1:0] lane_result;

  for (genvar j = 0; j < N; j++) begin : g_lane
    ternary_select_unit #(
      .FEATURE_WIDTH (FEATURE_WIDTH),
      .KERNEL_WIDTH  (KERNEL_WIDTH)
    ) u_lane (
      .feature (feature_in[j*FEATURE_WIDTH +: FEATURE_WIDTH]),
      .weight  (weight_in[j*KERNEL_WIDTH +: KERNEL_WIDTH]),
      .result  (lane_result[j*FEATURE_WIDTH +: FEATURE_WIDTH])
    );
  end

  // Handshake: enable high at a rising edge captures all lanes; the next
  // cycle feature_out holds that result and ternary_com_done pulses for
  // exactly that cycle. There is no backpressure, so one result per enabled
  // cycle streams out, and feature_out holds between enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      feature_out      <= '0;
      ternary_com_done <= 1'b0;
    end else begin
      ternary_com_done <= enable;
      if (enable) begin
        feature_out <= lane_result;
      end
    end
  end

endmodule

// File: tb/tb_tnkk_select_array_unit.sv
// Self-checking bench for tnkk_select_array_unit: table-driven lane vectors,
// hand-written streaming/hold/reset sequences, and an expected-result queue.
module tb_tnkk_select_array_unit;
  import tnkk_select_array_unit_pkg::*;

  localparam int FW    = FEATURE_WIDTH_DEF;
  localparam int KW    = KERNEL_WIDTH_DEF;
  localparam int N     = TN_DEF * KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int BUS_W = N * FW;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [BUS_W-1:0]  feature_in;
  logic [N*KW-1:0]   weight_in;
  logic [BUS_W-1:0]  feature_out;
  logic              ternary_com_done;

  tnkk_select_array_unit dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .feature_in       (feature_in),
    .weight_in        (weight_in),
    .feature_out      (feature_out),
    .ternary_com_done (ternary_com_done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [BUS_W-1:0] exp_q[$];
  logic [BUS_W-1:0] cur_exp;
  logic [BUS_W-1:0] hold_val;
  int n_cmp;
  int n_bad;

  typedef struct {
    logic [FW-1:0] feat;
    logic [1:0]    code;
    logic [FW-1:0] expv;
  } vec_t;

  vec_t vecs[10];

  task automatic cmp_bus(input string name, input logic [BUS_W-1:0] act,
                         input logic [BUS_W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic cmp_bit(input string name, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, expv);
    end
  endtask

  // Independent reference for one lane, used only for random vectors.
  function automatic logic [FW-1:0] ref_lane(input logic [FW-1:0] f,
                                             input logic [1:0] c);
    if (c == 2'b01) return f;
    if (c == 2'b11) return ~f + 1'b1;
    return '0;
  endfunction

  task automatic set_lane(input int j, input logic [FW-1:0] f,
                          input logic [1:0] c, input logic [FW-1:0] e);
    feature_in[j*FW +: FW] = f;
    weight_in[j*KW +: KW]  = KW'(c);
    cur_exp[j*FW +: FW]    = e;
  endtask

  // Outputs observed 1 time unit after the rising edge.
  task automatic check_outputs();
    logic [BUS_W-1:0] e;
    if (ternary_com_done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty: got done=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        cmp_bus("result", feature_out, e);
        hold_val = e;
      end
    end else begin
      cmp_bus("hold", feature_out, hold_val);
    end
  endtask

  task automatic tick();
    logic exp_done;
    exp_done = enable && rst;
    if (exp_done) exp_q.push_back(cur_exp);
    @(posedge clk);
    #1;
    cmp_bit("done", ternary_com_done, exp_done);
    check_outputs();
  endtask

  task automatic drive_idle();
    enable = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    hold_val = '0;
    cur_exp = '0;
    enable = 1'b0;
    feature_in = '0;
    weight_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    cmp_bus("reset_out_async", feature_out, '0);
    cmp_bit("reset_done_async", ternary_com_done, 1'b0);

    // Enables during reset must not produce results.
    enable = 1'b1;
    for (int i = 0; i < N; i++) set_lane(i, 16'd7, 2'b01, 16'd7);
    tick();
    tick();
    enable = 1'b0;
    rst = 1'b1;
    tick();
    cmp_bus("post_reset_out", feature_out, '0);

    // First enable after release is honoured on the first edge.
    for (int i = 0; i < N; i++) set_lane(i, 16'd5, 2'b01, 16'd5);
    enable = 1'b1;
    tick();
    drive_idle();
    tick();

    vecs[0] = '{16'd100,  2'b01, 16'd100};
    vecs[1] = '{16'd100,  2'b11, 16'hFF9C};
    vecs[2] = '{16'd100,  2'b00, 16'h0000};
    vecs[3] = '{16'd100,  2'b10, 16'h0000};
    vecs[4] = '{16'h8000, 2'b11, 16'h8000};
    vecs[5] = '{16'h7FFF, 2'b11, 16'h8001};
    vecs[6] = '{16'h0001, 2'b11, 16'hFFFF};
    vecs[7] = '{16'hFFFF, 2'b11, 16'h0001};
    vecs[8] = '{16'h1234, 2'b01, 16'h1234};
    vecs[9] = '{16'h8000, 2'b01, 16'h8000};

    // Code coverage pattern: codes cycle 01,11,00,10 across lanes.
    for (int i = 0; i < N; i++) set_lane(i, vecs[i%4].feat, vecs[i%4].code, vecs[i%4].expv);
    enable = 1'b1;
    tick();
    drive_idle();
    tick();
    tick();

    // Table rotations: every lane sees every vector over the sweep.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) begin
        set_lane(i, vecs[(i+v)%10].feat, vecs[(i+v)%10].code, vecs[(i+v)%10].expv);
      end
      enable = 1'b1;
      tick();
      if (v % 3 == 2) begin
        drive_idle();
        tick();
      end
    end
    drive_idle();
    tick();

    // Streaming 1,2,3,4 then hold.
    for (int s = 1; s <= 4; s++) begin
      for (int i = 0; i < N; i++) set_lane(i, FW'(s), 2'b01, FW'(s));
      enable = 1'b1;
      tick();
    end
    drive_idle();
    tick();
    cmp_bus("stream_hold4", feature_out, {N{16'd4}});

    // Hold while inputs toggle randomly.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        feature_in[i*FW +: FW] = FW'($urandom_range(0, 65535));
        weight_in[i*KW +: KW]  = KW'($urandom_range(0, 3));
      end
      #2;
      tick();
    end

    // Random vectors against the reference lane function.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        logic [FW-1:0] f;
        logic [1:0] c;
        f = FW'($urandom_range(0, 65535));
        c = 2'($urandom_range(0, 3));
        set_lane(i, f, c, ref_lane(f, c));
      end
      enable = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive_idle();
    tick();

    // Asynchronous reset between edges during streaming.
    for (int i = 0; i < N; i++) set_lane(i, 16'h0ABC, 2'b01, 16'h0ABC);
    enable = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    cmp_bus("async_rst_out", feature_out, '0);
    cmp_bit("async_rst_done", ternary_com_done, 1'b0);
    exp_q.delete();
    hold_val = '0;
    tick();
    tick();
    enable = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    // Everything pushed must have been consumed.
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
